elm_axis_tx: RTL and testbench

ELM_AXIS_TX -- requirements
Module: elm_axis_tx

---
 rtl/elm_axis_tx.sv | 121 ++++++++++++
 tb/tb_elm_axis_tx.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elm_axis_tx.sv
// Serialises a result vector onto an AXI-Stream master, one neuron value per beat,
// optionally followed by a beat carrying the index of the largest (signed) value.
module elm_axis_tx #(
    parameter int DATA_WIDTH    = 16,
    parameter int NUM_WORDS     = 2,
    parameter int APPEND_ARGMAX = 1
) (
    input  logic                            s_axi_aclk,
    input  logic                            reset,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic                            busy,
    output logic [7:0]                      drop_count
);

    localparam int BW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, SEND, INDEX} state_t;

    state_t                          state_reg, state_next;
    logic [NUM_WORDS*DATA_WIDTH-1:0] hold_reg, hold_next;
    logic [BW-1:0]                   beat_reg, beat_next;
    logic [DATA_WIDTH-1:0]           max_val_reg, max_val_next;
    logic [BW-1:0]                   max_idx_reg, max_idx_next;
    logic [7:0]                      drop_reg, drop_next;

    logic [DATA_WIDTH-1:0] words [NUM_WORDS];
    logic [DATA_WIDTH-1:0] cur_word;

    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_words
            assign words[gi] = hold_reg[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign cur_word   = words[beat_reg];
    assign busy       = (state_reg != IDLE);
    assign drop_count = drop_reg;

    always_comb begin
        state_next    = state_reg;
        hold_next     = hold_reg;
        beat_next     = beat_reg;
        max_val_next  = max_val_reg;
        max_idx_next  = max_idx_reg;
        drop_next     = drop_reg;
        in_ready      = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;

        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    hold_next    = in_data;
                    beat_next    = '0;
                    max_val_next = in_data[DATA_WIDTH-1:0];
                    max_idx_next = '0;
                    state_next   = SEND;
                end
            end
            SEND: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = cur_word;
                m_axis_tlast  = (APPEND_ARGMAX == 0) && (beat_reg == LAST_BEAT);
                if (m_axis_tready) begin
                    // Strictly-greater keeps the lowest index on ties.
                    if ((beat_reg != '0) && ($signed(cur_word) > $signed(max_val_reg))) begin
                        max_val_next = cur_word;
                        max_idx_next = beat_reg;
                    end
                    if (beat_reg == LAST_BEAT) begin
                        state_next = (APPEND_ARGMAX != 0) ? INDEX : IDLE;
                    end else begin
                        beat_next = beat_reg + 1'b1;
                    end
                end
            end
            INDEX: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tdata  = DATA_WIDTH'(max_idx_reg);
                if (m_axis_tready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Vectors offered while a packet is in flight are lost; count them, saturating.
        if (in_valid && (state_reg != IDLE) && (drop_reg != 8'hFF)) begin
            drop_next = drop_reg + 1'b1;
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            state_reg   <= IDLE;
            hold_reg    <= '0;
            beat_reg    <= '0;
            max_val_reg <= '0;
            max_idx_reg <= '0;
            drop_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            hold_reg    <= hold_next;
            beat_reg    <= beat_next;
            max_val_reg <= max_val_next;
            max_idx_reg <= max_idx_next;
            drop_reg    <= drop_next;
        end
    end

endmodule

// File: tb/tb_elm_axis_tx.sv
// Scoreboard bench for elm_axis_tx: expected beats queued at stimulus time,
// compared against beats captured by a monitor on each AXI-Stream handshake.
module tb_elm_axis_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid, in_ready;
    logic [15:0] tdata;
    logic        tvalid, tready, tlast, busy;
    logic [7:0]  drop_count;

    logic [31:0] in_data0;
    logic        in_valid0, in_ready0;
    logic [15:0] tdata0;
    logic        tvalid0, tready0, tlast0, busy0;
    logic [7:0]  drop_count0;

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          cyc;
    } beat_t;

    beat_t obs_q[$];
    beat_t obs0_q[$];
    beat_t exp_q[$];
    int    obs_rd = 0;
    int    obs0_rd = 0;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    elm_axis_tx #(.DATA_WIDTH(16), .NUM_WORDS(2), .APPEND_ARGMAX(1)) dut (
        .s_axi_aclk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast), .busy(busy), .drop_count(drop_count)
    );

    elm_axis_tx #(.DATA_WIDTH(16), .NUM_WORDS(2), .APPEND_ARGMAX(0)) dut0 (
        .s_axi_aclk(clk), .reset(reset), .in_data(in_data0), .in_valid(in_valid0),
        .in_ready(in_ready0), .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0),
        .m_axis_tready(tready0), .m_axis_tlast(tlast0), .busy(busy0), .drop_count(drop_count0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic beat_t mk(input logic [15:0] d, input logic l, input int c);
        beat_t b;
        b.data = d;
        b.last = l;
        b.cyc  = c;
        return b;
    endfunction

    // Monitor: a beat is a transfer only if the coming edge is not a reset edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (tvalid && tready)   obs_q.push_back(mk(tdata, tlast, cyc));
            if (tvalid0 && tready0) obs0_q.push_back(mk(tdata0, tlast0, cyc));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_vec(input logic [15:0] w1, input logic [15:0] w0,
                            input logic [15:0] idx, output int acc);
        int n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_wait in_ready=%b required 1", in_ready);
        end
        in_data  = {w1, w0};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        acc = cyc;
        exp_q.push_back(mk(w0, 1'b0, acc));
        exp_q.push_back(mk(w1, 1'b0, acc + 1));
        exp_q.push_back(mk(idx, 1'b1, acc + 2));
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_valid0 = 1'b1;
        in_data = 32'h1234_5678; in_data0 = 32'h1111_2222;
        tready = 1'b1; tready0 = 1'b1;
        repeat (3) step();
        reset = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b required 0", tvalid); end
        checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b required 0", tlast); end
        checks++; if (tdata !== 16'h0000) begin errors++; $display("FAIL reset_tdata got %h required 0000", tdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d required 0", drop_count); end
        step();
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_idle_tvalid got %b required 0", tvalid); end
    endtask

    task automatic test_basic();
        int acc, n;
        beat_t e, o;
        tready = 1'b1;
        send_vec(16'hFFFE, 16'h0005, 16'h0000, acc);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b required 1", busy); end
        n = 0;
        while (obs_q.size() < obs_rd + exp_q.size() && n < 100) begin step(); n++; end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after got %b required 1", in_ready); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                errors++; $display("FAIL basic_beat missing, required data=%h last=%b", e.data, e.last);
            end else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.data !== e.data || o.last !== e.last || o.cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL basic_beat got data=%h last=%b cyc=%0d required data=%h last=%b cyc=%0d",
                             o.data, o.last, o.cyc, e.data, e.last, e.cyc);
                end
            end
        end
    endtask

    task automatic test_stall();
        int acc, n;
        beat_t e, o;
        logic stall;
        logic [15:0] pd;
        logic pl;
        tready = 1'b1;
        send_vec(16'h7FFF, 16'h0003, 16'h0001, acc);
        for (int i = 0; i < 15; i++) begin
            tready = (i % 3 == 0);
            stall  = tvalid && !tready;
            pd = tdata; pl = tlast;
            step();
            if (stall) begin
                checks++;
                if (tvalid !== 1'b1 || tdata !== pd || tlast !== pl) begin
                    errors++;
                    $display("FAIL stall_stable got v=%b d=%h l=%b required v=1 d=%h l=%b", tvalid, tdata, tlast, pd, pl);
                end
            end
        end
        tready = 1'b1;
        n = 0;
        while (obs_q.size() < obs_rd + exp_q.size() && n < 100) begin step(); n++; end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                errors++; $display("FAIL stall_beat missing, required data=%h last=%b", e.data, e.last);
            end else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.data !== e.data || o.last !== e.last) begin
                    errors++;
                    $display("FAIL stall_beat got data=%h last=%b required data=%h last=%b", o.data, o.last, e.data, e.last);
                end
            end
        end
    endtask

    task automatic test_argmax_ties();
        int acc, n;
        beat_t e, o;
        tready = 1'b1;
        send_vec(16'h0004, 16'h0004, 16'h0000, acc);
        send_vec(16'h8000, 16'hFFFF, 16'h0000, acc);
        n = 0;
        while (obs_q.size() < obs_rd + exp_q.size() && n < 100) begin step(); n++; end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                errors++; $display("FAIL ties_beat missing, required data=%h last=%b", e.data, e.last);
            end else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.data !== e.data || o.last !== e.last || o.cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL ties_beat got data=%h last=%b cyc=%0d required data=%h last=%b cyc=%0d",
                             o.data, o.last, o.cyc, e.data, e.last, e.cyc);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        beat_t e, o;
        tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data  = {16'(i + 16), 16'(i)};
            in_valid = 1'b1;
            if (i == 0 || i == 4 || i == 8) begin
                exp_q.push_back(mk(16'(i), 1'b0, cyc + 1));
                exp_q.push_back(mk(16'(i + 16), 1'b0, cyc + 2));
                exp_q.push_back(mk(16'h0001, 1'b1, cyc + 3));
            end
            step();
        end
        in_valid = 1'b0;
        n = 0;
        while (obs_q.size() < obs_rd + exp_q.size() && n < 100) begin step(); n++; end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                errors++; $display("FAIL b2b_beat missing, required data=%h last=%b", e.data, e.last);
            end else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.data !== e.data || o.last !== e.last || o.cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL b2b_beat got data=%h last=%b cyc=%0d required data=%h last=%b cyc=%0d",
                             o.data, o.last, o.cyc, e.data, e.last, e.cyc);
                end
            end
        end
        checks++; if (drop_count !== 8'd7) begin errors++; $display("FAIL b2b_drop got %0d required 7", drop_count); end
        in_valid = 1'b1;
        repeat (400) step();
        in_valid = 1'b0;
        repeat (10) step();
        obs_rd = obs_q.size();
        checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL drop_saturate got %0d required 255", drop_count); end
    endtask

    task automatic test_reset_mid();
        int acc, n;
        beat_t e, o;
        tready = 1'b1;
        in_data  = {16'h0011, 16'h0022};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        acc = cyc;
        exp_q.push_back(mk(16'h0022, 1'b0, acc));
        step();
        reset = 1'b1; in_valid = 1'b1;
        step();
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL mid_reset_tvalid got %b required 0", tvalid); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL mid_reset_drop got %0d required 0", drop_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b required 0", busy); end
        reset = 1'b0; in_valid = 1'b0;
        send_vec(16'h0001, 16'h0009, 16'h0000, acc);
        n = 0;
        while (obs_q.size() < obs_rd + exp_q.size() && n < 100) begin step(); n++; end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                errors++; $display("FAIL mid_beat missing, required data=%h last=%b", e.data, e.last);
            end else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.data !== e.data || o.last !== e.last || o.cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL mid_beat got data=%h last=%b cyc=%0d required data=%h last=%b cyc=%0d",
                             o.data, o.last, o.cyc, e.data, e.last, e.cyc);
                end
            end
        end
        checks++; if (obs_q.size() !== obs_rd) begin errors++; $display("FAIL mid_extra_beats got %0d required 0", obs_q.size() - obs_rd); end
    endtask

    task automatic test_no_argmax();
        int acc, n;
        beat_t e, o;
        tready0   = 1'b1;
        in_data0  = {16'h0002, 16'h0001};
        in_valid0 = 1'b1;
        step();
        in_valid0 = 1'b0;
        acc = cyc;
        exp_q.push_back(mk(16'h0001, 1'b0, acc));
        exp_q.push_back(mk(16'h0002, 1'b1, acc + 1));
        repeat (6) step();
        checks++; if (obs0_q.size() - obs0_rd !== 2) begin errors++; $display("FAIL noargmax_len got %0d required 2", obs0_q.size() - obs0_rd); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs0_rd >= obs0_q.size()) begin
                errors++; $display("FAIL noargmax_beat missing, required data=%h last=%b", e.data, e.last);
            end else begin
                o = obs0_q[obs0_rd]; obs0_rd++;
                if (o.data !== e.data || o.last !== e.last || o.cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL noargmax_beat got data=%h last=%b cyc=%0d required data=%h last=%b cyc=%0d",
                             o.data, o.last, o.cyc, e.data, e.last, e.cyc);
                end
            end
        end
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL noargmax_ready got %b required 1", in_ready0); end
        n = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_argmax_ties();
        test_back_to_back();
        test_reset_mid();
        test_no_argmax();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
